mem_access_unit: RTL and testbench

- Memory-stage data-bus master. Turns load/store requests from the pipeline into word-aligned bus transactions.
- Store side: places byte/half data into the correct lanes and generates byte enables.
- Load side: shifts the selected lanes down to bit 0, zero-filled, for the write-stage extender to sign/zero-extend.
- Detects misaligned addresses and bus timeouts, and stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory-stage access unit (master) and a
// word-organised slave.
//
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata
// and holds all of them stable until the slave raises bus_ready; the
// transaction completes in the cycle where bus_req and bus_ready are both 1,
// and bus_rdata is only meaningful in that cycle. The master may abandon a
// request only on reset or on its own timeout.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master. Accepts one load/store from the pipeline,
// steers store data into byte lanes, issues a word-aligned bus transaction,
// returns load lanes shifted down to bit 0 and raises address-error or
// bus-timeout exceptions. dbg_state exposes the FSM state for checkers.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    output logic               done,
    output logic [31:0]        rdata_lane,
    output logic               exc_valid,
    output logic [4:0]         exc_code,
    output logic [1:0]         dbg_state,
    mem_access_unit_if.master  bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched transaction context, stable for the whole BUSY phase.
    logic [29:0]   addr_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          exc_to_q;

    logic          misaligned;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [31:0]   load_data;
    logic [31:0]   rdata_shift;
    logic          accept;
    logic          timeout_hit;

    // Address alignment check for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Byte-enable and lane-replicated store data for the incoming request.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
        case (req_size)
            2'd0: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
        endcase
    end

    // Shift the addressed load lanes down to bit 0, upper bits zero.
    always_comb begin
        rdata_shift = bus.bus_rdata >> {lane_q, 3'b000};
        load_data   = bus.bus_rdata;
        case (size_q)
            2'd0:    load_data = {24'h0, rdata_shift[7:0]};
            2'd1:    load_data = lane_q[1] ? {16'h0, bus.bus_rdata[31:16]}
                                           : {16'h0, bus.bus_rdata[15:0]};
            default: load_data = bus.bus_rdata;
        endcase
    end

    // FSM next state and handshake outputs. The cycle carrying a timeout
    // exception ignores req_valid so an exception never coincides with a new
    // acceptance.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        exc_valid   = exc_to_q;
        exc_code    = exc_to_q ? EXC_DBE : 5'd0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !exc_to_q) begin
                    if (misaligned) begin
                        exc_valid = 1'b1;
                        exc_code  = req_write ? EXC_ADES : EXC_ADEL;
                    end else begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (bus.bus_ready) begin
                    state_nxt = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_RESP: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transaction context, wait counter, load result and timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            exc_to_q <= 1'b0;
        end else begin
            exc_to_q <= timeout_hit;
            if (accept) begin
                addr_q  <= req_addr[31:2];
                we_q    <= req_write;
                be_q    <= be_calc;
                wdata_q <= wdata_calc;
                size_q  <= req_size;
                lane_q  <= req_addr[1:0];
                cnt_q   <= '0;
            end else if (state == ST_BUSY) begin
                if (bus.bus_ready) begin
                    rdata_q <= we_q ? 32'h0 : load_data;
                end else if (!timeout_hit) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.bus_req   = (state == ST_BUSY);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q, 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign rdata_lane    = rdata_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: store/load lane steering, wait states,
// misalignment exceptions, bus timeout, reset mid-transaction and
// back-to-back requests. Inputs change 1 time unit after posedge, outputs
// are sampled on negedge.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_lane;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    int cnt;

    mem_access_unit_if bus_if();

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata_lane(rdata_lane),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .dbg_state (dbg_state),
        .bus       (bus_if)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle_cycle;
        next_cycle;
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        bus_if.bus_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        sample;
        check("rst_state", dbg_state, 32'd0);
        check("rst_req",   bus_if.bus_req, 32'd0);
        check("rst_addr",  bus_if.bus_addr, 32'h0);
        check("rst_be",    bus_if.bus_be, 32'h0);
        check("rst_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_we",    bus_if.bus_we, 32'd0);
        check("rst_lane",  rdata_lane, 32'h0);
        check("rst_flags", {stall, done, exc_valid}, 32'd0);

        // Store byte at 0x1003, zero-wait slave.
        next_cycle;
        set_req(1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB);
        sample;
        check("sb_c0_stall", stall, 32'd1);
        check("sb_c0_req",   bus_if.bus_req, 32'd0);
        next_cycle;
        bus_if.bus_ready = 1'b1;
        sample;
        check("sb_c1_req",   bus_if.bus_req, 32'd1);
        check("sb_c1_stall", stall, 32'd1);
        check("sb_addr",     bus_if.bus_addr, 32'h0000_1000);
        check("sb_be",       bus_if.bus_be, 32'h8);
        check("sb_wdata",    bus_if.bus_wdata, 32'hABAB_ABAB);
        check("sb_we",       bus_if.bus_we, 32'd1);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        sample;
        check("sb_c2_done",  done, 32'd1);
        check("sb_c2_stall", stall, 32'd0);
        check("sb_c2_req",   bus_if.bus_req, 32'd0);
        check("sb_c2_lane",  rdata_lane, 32'h0);
        idle_cycle;

        // Load half at 0x2002, three wait cycles.
        cnt = 0;
        next_cycle;
        set_req(1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0);
        sample;
        cnt += int'(stall);
        for (int i = 0; i < 3; i++) begin
            next_cycle;
            sample;
            cnt += int'(stall);
            check("lh_wait_req", bus_if.bus_req, 32'd1);
            check("lh_wait_done", done, 32'd0);
        end
        next_cycle;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h8765_4321;
        sample;
        cnt += int'(stall);
        check("lh_be",   bus_if.bus_be, 32'hC);
        check("lh_we",   bus_if.bus_we, 32'd0);
        check("lh_addr", bus_if.bus_addr, 32'h0000_2000);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        sample;
        cnt += int'(stall);
        check("lh_done",  done, 32'd1);
        check("lh_lane",  rdata_lane, 32'h0000_8765);
        check("lh_stall_cycles", cnt, 32'd5);
        idle_cycle;

        // Misaligned load word and store half.
        next_cycle;
        set_req(1'b1, 1'b0, 2'd2, 32'h0000_3001, 32'h0);
        sample;
        check("adel_exc",   exc_valid, 32'd1);
        check("adel_code",  exc_code, 32'd4);
        check("adel_stall", stall, 32'd0);
        check("adel_req",   bus_if.bus_req, 32'd0);
        next_cycle;
        set_req(1'b1, 1'b1, 2'd1, 32'h0000_3001, 32'h1234);
        sample;
        check("ades_exc",   exc_valid, 32'd1);
        check("ades_code",  exc_code, 32'd5);
        check("ades_state", dbg_state, 32'd0);
        check("ades_req",   bus_if.bus_req, 32'd0);
        idle_cycle;
        sample;
        check("mis_after_exc", exc_valid, 32'd0);

        // Bus timeout: no ready for 16 BUSY cycles.
        cnt = 0;
        next_cycle;
        set_req(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0);
        sample;
        for (int i = 0; i < 16; i++) begin
            next_cycle;
            sample;
            cnt += int'(bus_if.bus_req);
            check("to_no_exc", exc_valid, 32'd0);
        end
        check("to_req_cycles", cnt, 32'd16);
        next_cycle;
        sample;
        check("to_exc",   exc_valid, 32'd1);
        check("to_code",  exc_code, 32'd7);
        check("to_stall", stall, 32'd0);
        check("to_state", dbg_state, 32'd0);
        check("to_req",   bus_if.bus_req, 32'd0);
        check("to_done",  done, 32'd0);
        idle_cycle;
        sample;
        check("to_pulse_end", exc_valid, 32'd0);

        // Ready in the 16th BUSY cycle wins over the timeout.
        next_cycle;
        set_req(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0);
        sample;
        for (int i = 0; i < 15; i++) begin
            next_cycle;
            sample;
        end
        next_cycle;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'hCAFE_F00D;
        sample;
        check("tw_req", bus_if.bus_req, 32'd1);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        sample;
        check("tw_done", done, 32'd1);
        check("tw_exc",  exc_valid, 32'd0);
        check("tw_lane", rdata_lane, 32'hCAFE_F00D);
        idle_cycle;
        sample;
        check("tw_no_late_exc", exc_valid, 32'd0);

        // Reset during the second BUSY cycle.
        next_cycle;
        set_req(1'b1, 1'b0, 2'd0, 32'h0000_0020, 32'h0);
        next_cycle;
        sample;
        check("rb_busy1", bus_if.bus_req, 32'd1);
        next_cycle;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        next_cycle;
        reset = 1'b0;
        sample;
        check("rb_req",   bus_if.bus_req, 32'd0);
        check("rb_stall", stall, 32'd0);
        check("rb_done",  done, 32'd0);
        check("rb_be",    bus_if.bus_be, 32'h0);
        next_cycle;
        set_req(1'b1, 1'b1, 2'd2, 32'h0000_0010, 32'h1234_5678);
        next_cycle;
        bus_if.bus_ready = 1'b1;
        sample;
        check("rs_addr",  bus_if.bus_addr, 32'h0000_0010);
        check("rs_be",    bus_if.bus_be, 32'hF);
        check("rs_wdata", bus_if.bus_wdata, 32'h1234_5678);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        sample;
        check("rs_done", done, 32'd1);
        idle_cycle;

        // Back-to-back: load byte at 0x5001, then store word to 0x5004.
        next_cycle;
        set_req(1'b1, 1'b0, 2'd0, 32'h0000_5001, 32'h0);
        next_cycle;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h1122_3344;
        sample;
        check("bb_lb_be", bus_if.bus_be, 32'h2);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        set_req(1'b1, 1'b1, 2'd2, 32'h0000_5004, 32'hDEAD_BEEF);
        sample;
        check("bb_lb_done",  done, 32'd1);
        check("bb_lb_lane",  rdata_lane, 32'h0000_0033);
        check("bb_lb_stall", stall, 32'd0);
        next_cycle;
        sample;
        check("bb_sw_accept", stall, 32'd1);
        check("bb_sw_state",  dbg_state, 32'd0);
        check("bb_sw_nodone", done, 32'd0);
        next_cycle;
        bus_if.bus_ready = 1'b1;
        sample;
        check("bb_sw_req",   bus_if.bus_req, 32'd1);
        check("bb_sw_addr",  bus_if.bus_addr, 32'h0000_5004);
        check("bb_sw_be",    bus_if.bus_be, 32'hF);
        check("bb_sw_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
        check("bb_sw_we",    bus_if.bus_we, 32'd1);
        next_cycle;
        bus_if.bus_ready = 1'b0;
        sample;
        check("bb_sw_done", done, 32'd1);
        check("bb_sw_lane", rdata_lane, 32'h0);
        idle_cycle;
        sample;
        check("bb_end_state", dbg_state, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
